// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and instruction memory.
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] rdata;
    logic               ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack bus into the instruction
// register, and advances the PC (sequential or jump) once the datapath signals completion.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               j,
    input  logic               jc,
    input  logic               neq,
    input  logic               eq,
    input  logic [ADDR_W-1:0]  jmp_addr,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               w_fetch_fire;
    logic               w_exec_fire;
    logic               w_taken;

    assign w_fetch_fire = (r_state == S_FETCH) && imem.ack;
    assign w_exec_fire  = (r_state == S_EXEC) && exec_done;
    // eq ^ neq is true exactly when the comparison matches the requested sense
    assign w_taken      = j | (jc & (eq ^ neq));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_FETCH;
            S_FETCH: if (imem.ack) w_state_next = S_EXEC;
            S_EXEC:  if (exec_done) w_state_next = halt ? S_HALT : S_FETCH;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            if (w_fetch_fire) begin
                r_instr <= imem.rdata;
            end
            if (w_exec_fire) begin
                r_pc <= w_taken ? jmp_addr : r_pc + 1'b1;
            end
        end
    end

    assign imem.req    = (r_state == S_FETCH);
    assign imem.addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[INSTR_W-1 -: 3];
    assign instr_valid = (r_state == S_EXEC);
    assign halted      = (r_state == S_HALT);
    assign pc          = r_pc;
endmodule
